// File: rtl/axi_lite_mem_arbiter.sv
// Two-master AXI4-lite arbiter: IFU (M0, read-only) and LSU (M1, read/write) share one slave.
// Define ARB_RR_EN to alternate between M0 reads and M1 requests; otherwise M1 has fixed priority.
module axi_lite_mem_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // M0 (IFU) read channels
  input  logic [AW-1:0]   m0_araddr,
  input  logic            m0_arvalid,
  output logic            m0_arready,
  output logic [DW-1:0]   m0_rdata,
  output logic [1:0]      m0_rresp,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  // M1 (LSU) read channels
  input  logic [AW-1:0]   m1_araddr,
  input  logic            m1_arvalid,
  output logic            m1_arready,
  output logic [DW-1:0]   m1_rdata,
  output logic [1:0]      m1_rresp,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  // M1 (LSU) write channels
  input  logic [AW-1:0]   m1_awaddr,
  input  logic            m1_awvalid,
  output logic            m1_awready,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_wvalid,
  output logic            m1_wready,
  output logic [1:0]      m1_bresp,
  output logic            m1_bvalid,
  input  logic            m1_bready,
  // Slave side
  output logic [AW-1:0]   s_araddr,
  output logic            s_arvalid,
  input  logic            s_arready,
  input  logic [DW-1:0]   s_rdata,
  input  logic [1:0]      s_rresp,
  input  logic            s_rvalid,
  output logic            s_rready,
  output logic [AW-1:0]   s_awaddr,
  output logic            s_awvalid,
  input  logic            s_awready,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  output logic            s_wvalid,
  input  logic            s_wready,
  input  logic [1:0]      s_bresp,
  input  logic            s_bvalid,
  output logic            s_bready
);

  typedef enum logic [1:0] {StIdle, StRdM0, StRdM1, StWrM1} state_e;

  state_e state_q, state_d;
  logic   addr_done_q, addr_done_d;
  logic   w_done_q, w_done_d;
`ifdef ARB_RR_EN
  logic   last_grant_q, last_grant_d;
`endif

  always_comb begin
    state_d     = state_q;
    addr_done_d = addr_done_q;
    w_done_d    = w_done_q;
`ifdef ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bresp   = '0;
    m1_bvalid  = 1'b0;
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        addr_done_d = 1'b0;
        w_done_d    = 1'b0;
        if (m1_awvalid || m1_wvalid) begin
          state_d = StWrM1;
        end else if (m1_arvalid) begin
          state_d = StRdM1;
        end else if (m0_arvalid) begin
          state_d = StRdM0;
        end
`ifdef ARB_RR_EN
        // M1 was granted last: let the pending IFU read go first this time.
        if (m0_arvalid && (m1_awvalid || m1_wvalid || m1_arvalid) && last_grant_q) begin
          state_d = StRdM0;
        end
        if (state_d == StRdM0) begin
          last_grant_d = 1'b0;
        end else if (state_d != StIdle) begin
          last_grant_d = 1'b1;
        end
`endif
      end
      StRdM0: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid && !addr_done_q;
        m0_arready = s_arready && !addr_done_q;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
        if (m0_arvalid && s_arready && !addr_done_q) addr_done_d = 1'b1;
        if (s_rvalid && m0_rready) state_d = StIdle;
      end
      StRdM1: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid && !addr_done_q;
        m1_arready = s_arready && !addr_done_q;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
        if (m1_arvalid && s_arready && !addr_done_q) addr_done_d = 1'b1;
        if (s_rvalid && m1_rready) state_d = StIdle;
      end
      StWrM1: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid && !addr_done_q;
        m1_awready = s_awready && !addr_done_q;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid && !w_done_q;
        m1_wready  = s_wready && !w_done_q;
        m1_bresp   = s_bresp;
        m1_bvalid  = s_bvalid;
        s_bready   = m1_bready;
        if (m1_awvalid && s_awready && !addr_done_q) addr_done_d = 1'b1;
        if (m1_wvalid && s_wready && !w_done_q) w_done_d = 1'b1;
        if (s_bvalid && m1_bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_done_q <= 1'b0;
      w_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_done_q <= addr_done_d;
      w_done_q    <= w_done_d;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

endmodule

// File: doc/axi_lite_mem_arbiter.md
Name: axi_lite_mem_arbiter

Overview:
- Shares one AXI4-lite memory slave between two masters.
- M0 is the instruction fetch unit, read channels only. M1 is the load/store unit, with full read and write channels.
- Grants one whole transaction at a time: AR→R for a read, AW+W→B for a write. The slave is re-arbitrated only after the response handshake completes.
- Sits between the fetch/LSU pair and the memory/crossbar slave.

Parameters:
- AW, 32, address width of all address channels.
- DW, 32, data width of R and W channels; WSTRB width is DW/8.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- m0 AR: m0_araddr in AW; m0_arvalid in 1; m0_arready out 1. IFU read address.
- m0 R: m0_rdata out DW; m0_rresp out 2; m0_rvalid out 1; m0_rready in 1. IFU read data.
- m1 AR: m1_araddr in AW; m1_arvalid in 1; m1_arready out 1. LSU read address.
- m1 R: m1_rdata out DW; m1_rresp out 2; m1_rvalid out 1; m1_rready in 1. LSU read data.
- m1 AW: m1_awaddr in AW; m1_awvalid in 1; m1_awready out 1. LSU write address.
- m1 W: m1_wdata in DW; m1_wstrb in DW/8; m1_wvalid in 1; m1_wready out 1. LSU write data.
- m1 B: m1_bresp out 2; m1_bvalid out 1; m1_bready in 1. LSU write response.
- s AR: s_araddr out AW; s_arvalid out 1; s_arready in 1. Slave read address.
- s R: s_rdata in DW; s_rresp in 2; s_rvalid in 1; s_rready out 1. Slave read data.
- s AW: s_awaddr out AW; s_awvalid out 1; s_awready in 1. Slave write address.
- s W: s_wdata out DW; s_wstrb out DW/8; s_wvalid out 1; s_wready in 1. Slave write data.
- s B: s_bresp in 2; s_bvalid in 1; s_bready out 1. Slave write response.

Behaviour:
- **States:** IDLE, RD_M0, RD_M1, WR_M1 (2-bit register). rst low → IDLE immediately, asynchronously. No other internal storage except the optional RR pointer.
- **IDLE:** all s_* valid/ready outputs 0; all m*_ ready/valid outputs 0; s_* address/data outputs 0. Requests are sampled in IDLE.
- **Next-state in IDLE (fixed priority):** m1_awvalid|m1_wvalid → WR_M1; else m1_arvalid → RD_M1; else m0_arvalid → RD_M0; else stay.
- **Arbitration latency:** 1 cycle. Grant is visible in the cycle after the request is first seen in IDLE. No master-side handshake occurs in IDLE.
- **RD_Mx:** combinational pass-through of the granted master's AR and R channels to/from s_AR/s_R. Non-granted masters see ready=0, valid=0, rdata=0, rresp=0. s_aw*/s_w*/s_bready held 0. On s_rvalid&s_rready → IDLE.
- **WR_M1:** pass-through of m1 AW, W and B. AW and W may complete in either order or together; the arbiter does not reorder them. On s_bvalid&s_bready → IDLE. All read channels are blocked.
- **One outstanding transaction max.** A second AR from the granted master before its R completes is blocked: s_arvalid is forced 0 once the AR handshake is done.
  - This uses a 1-bit "addr_done" flag per state, cleared on entry.
  - Same rule for AW and W in WR_M1 (separate aw_done and w_done flags).
- **Back-to-back:** the response handshake cycle moves to IDLE; the next grant is earliest 2 cycles after the response handshake.
- **Responses:** rresp/bresp forwarded unchanged, including SLVERR/DECERR. The arbiter never generates errors.
- **Mid-transaction reset:** all s_* valids drop in the same cycle rst goes low. The slave is assumed reset by the same rst.
- **No timeout.** A stalled slave holds the grant indefinitely.

Optional Feature:
- Macro: ARB_RR_EN.
- **Defined:** 1-bit last_grant register (reset 0 = M0).
  - In IDLE with both an M0 read and any M1 request pending, grant the master not granted last. last_grant updates on each entry to RD_M0/RD_M1/WR_M1.
  - Within M1, write still beats read.
- **Undefined:** fixed priority as above, so M1 can starve M0.

Test Plan:
- Reset: rst=0 with m0_arvalid=1 → m0_arready=0, s_arvalid=0. Release rst → s_arvalid=1, s_araddr=m0_araddr=0x80000000 on the second cycle.
- M0 read: araddr 0x80000004; slave arready after 2 cycles; rdata=0x00100093, rresp=0 → m0_rdata=0x00100093 with m0_rvalid=1, m1_rvalid=0; state IDLE next cycle.
- M1 write: awaddr 0x80001000, wdata 0xDEADBEEF, wstrb 0xF; W accepted 1 cycle before AW; bresp=2 → m1_bresp=2, s_wdata/s_wstrb match; no read-channel activity.
- Contention: m0_arvalid and m1_arvalid both rise in IDLE → M1 served first, M0 next. With ARB_RR_EN and last_grant=M1 → M0 served first.
- Hold: during RD_M1, m1 asserts a second arvalid after the AR handshake → s_arvalid stays 0 until the R handshake, then re-arbitrated.
- Mid-read reset: rst low during RD_M0 after AR done → s_rready and m0_arready 0 in that cycle; after release the state is IDLE and a fresh M0 read completes normally.
